// File: rtl/mux_sel_reg.sv
// ---------------------------------------------------------------------------
// mux_sel_reg
//   N-way operand selector with a single registered output stage and a
//   valid/ready handshake. Sits between the register-file/PC sources and the
//   ALU operand port of the multicycle datapath. One slot can be configured
//   to return a fixed constant instead of its lane. Selects that fall outside
//   the populated slots return lane 0, are flagged with the data, and are
//   counted in a saturating counter.
//
// Handshake (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   valid must not depend on ready. in_ready = !out_valid || out_ready, so
//   the stage holds one entry and still sustains one transfer per cycle.
//   While out_valid && !out_ready the held data_out/sel_err stay frozen.
//
// Ports:
//   clk        in   1             rising-edge clock
//   reset      in   1             asynchronous, active-low reset
//   data_in    in   N_IN*WIDTH    packed lanes; lane k = data_in[k*WIDTH +: WIDTH]
//   selector   in   SEL_W         slot to forward, sampled only on accept
//   in_valid   in   1             producer presents a selection
//   in_ready   out  1             stage can accept this cycle
//   data_out   out  WIDTH         registered selected value
//   out_valid  out  1             data_out holds an unconsumed value
//   out_ready  in   1             consumer takes data_out this cycle
//   sel_err    out  1             registered with data_out: selector was >= N_IN
//   err_cnt    out  CNT_W         saturating count of accepted out-of-range selects
// ---------------------------------------------------------------------------
module mux_sel_reg #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       N_IN       = 5,
  parameter int unsigned       SEL_W      = 3,
  parameter int unsigned       CONST_SLOT = 1,
  parameter logic [WIDTH-1:0]  CONST_VAL  = WIDTH'(4),
  parameter int unsigned       CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      selector,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [CNT_W-1:0]      err_cnt
);

  // CONST_SLOT == N_IN (or larger) turns the constant slot off entirely.
  // Kept as a separate flag so the disable value never aliases a real slot
  // after truncation to SEL_W bits.
  localparam bit CONST_EN = (CONST_SLOT < N_IN);

  // -------------------------------------------------------------------------
  // Lane unpacking
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] lane [N_IN];

  for (genvar k = 0; k < N_IN; k++) begin : g_lane
    assign lane[k] = data_in[k*WIDTH +: WIDTH];
  end

  // -------------------------------------------------------------------------
  // Select decode
  // -------------------------------------------------------------------------
  logic [31:0]      sel_ext;
  logic             sel_oor;
  logic             const_hit;
  logic [WIDTH-1:0] lane_pick;
  logic [WIDTH-1:0] sel_value;

  assign sel_ext   = 32'(selector);
  assign sel_oor   = (sel_ext >= N_IN);
  assign const_hit = CONST_EN && (sel_ext == CONST_SLOT);

  // Explicit compare loop instead of lane[selector]: the selector range can
  // exceed N_IN, and this keeps the out-of-range case well defined (lane 0).
  always_comb begin
    lane_pick = lane[0];
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel_ext == k) begin
        lane_pick = lane[k];
      end
    end
  end

  always_comb begin
    sel_value = lane_pick;
    if (const_hit) begin
      sel_value = CONST_VAL;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  logic accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Output stage next-state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q,    data_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             cnt_full;

  assign cnt_full = (err_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    data_d      = data_q;
    sel_err_d   = sel_err_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      // Covers both a fresh load and drain+accept in the same cycle: the new
      // entry simply replaces the one being consumed, so no bubble appears.
      data_d      = sel_value;
      sel_err_d   = sel_oor;
      out_valid_d = 1'b1;
      if (sel_oor && !cnt_full) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      // Drain only; data_out and sel_err keep their last value.
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      data_q      <= data_d;
      sel_err_q   <= sel_err_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign sel_err   = sel_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_reg
//   Directed bench for mux_sel_reg. Two instances share all inputs: one with
//   default parameters and one with a 2-bit error counter to exercise
//   saturation. A transaction-level model predicts the held output entry and
//   is compared against both instances on every falling edge; directed
//   literal checks after each step pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_mux_sel_reg;

  localparam int W     = 32;
  localparam int N     = 5;
  localparam int SW    = 3;
  localparam int CW    = 8;
  localparam int CW_S  = 2;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Stimulus signals
  // -------------------------------------------------------------------------
  logic [W-1:0]   lanes [N];
  logic [N*W-1:0] data_in;
  logic [SW-1:0]  selector  = '0;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b0;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < N; k++) data_in[k*W +: W] = lanes[k];
  end

  // -------------------------------------------------------------------------
  // DUTs
  // -------------------------------------------------------------------------
  logic           in_ready,  in_ready_s;
  logic [W-1:0]   data_out,  data_out_s;
  logic           out_valid, out_valid_s;
  logic           sel_err,   sel_err_s;
  logic [CW-1:0]  err_cnt;
  logic [CW_S-1:0] err_cnt_s;

  mux_sel_reg dut (
    .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .err_cnt(err_cnt)
  );

  mux_sel_reg #(.CNT_W(CW_S)) dut_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
    .in_valid(in_valid), .in_ready(in_ready_s), .data_out(data_out_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .sel_err(sel_err_s),
    .err_cnt(err_cnt_s)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and check task
  // -------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: one pending output entry. An item is offered when in_valid is high
  // and the slot is free or being emptied; the selection rule is applied to
  // the slot number directly.
  // -------------------------------------------------------------------------
  bit          m_valid   = 0;
  logic [W-1:0] m_data   = '0;
  bit          m_err     = 0;
  int          m_cnt     = 0;
  int          m_cnt_sat = 0;

  function automatic logic [W-1:0] pick(input int s);
    if (s >= N) return lanes[0];
    if (s == 1) return 32'd4;
    return lanes[s];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_data = '0; m_err = 0; m_cnt = 0; m_cnt_sat = 0;
    end else begin
      bit slot_free;
      slot_free = !m_valid || out_ready;
      if (in_valid && slot_free) begin
        m_data  = pick(int'(selector));
        m_err   = (int'(selector) >= N);
        m_valid = 1;
        if (m_err) begin
          m_cnt     = (m_cnt + 1 > (1 << CW) - 1)       ? (1 << CW) - 1   : m_cnt + 1;
          m_cnt_sat = (m_cnt_sat + 1 > (1 << CW_S) - 1) ? (1 << CW_S) - 1 : m_cnt_sat + 1;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_valid",     out_valid,   m_valid);
    check("cyc_data",      data_out,    m_data);
    check("cyc_err",       sel_err,     m_err);
    check("cyc_cnt",       err_cnt,     m_cnt);
    check("cyc_ready",     in_ready,    !m_valid || out_ready);
    check("cyc_sat_valid", out_valid_s, m_valid);
    check("cyc_sat_data",  data_out_s,  m_data);
    check("cyc_sat_cnt",   err_cnt_s,   m_cnt_sat);
  end

  // Consumption counter: transfers out of the stage.
  int consumed = 0;
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) consumed++;
  end

  // -------------------------------------------------------------------------
  // Driver: apply inputs just after an edge, then advance one edge and let
  // registered outputs settle.
  // -------------------------------------------------------------------------
  task automatic step(input int sel, input bit v, input bit ordy);
    selector  = SW'(sel);
    in_valid  = v;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  logic [W-1:0] exp5 [8];
  int           sel5 [8];
  int           c0;

  initial begin
    lanes[0] = 32'hA0; lanes[1] = 32'hDEAD; lanes[2] = 32'hA2;
    lanes[3] = 32'hA3; lanes[4] = 32'hA4;

    // 1: reset state before the first edge
    #1;
    check("rst_data",   data_out,  32'h0);
    check("rst_valid",  out_valid, 1'b0);
    check("rst_ready",  in_ready,  1'b1);
    check("rst_cnt",    err_cnt,   8'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // 2: each slot once, full throughput
    step(0, 1, 1); check("t2_s0", data_out, 32'hA0); check("t2_v0", out_valid, 1);
    step(1, 1, 1); check("t2_s1", data_out, 32'h4);  check("t2_v1", out_valid, 1);
    step(2, 1, 1); check("t2_s2", data_out, 32'hA2); check("t2_v2", out_valid, 1);
    step(3, 1, 1); check("t2_s3", data_out, 32'hA3); check("t2_v3", out_valid, 1);
    step(4, 1, 1); check("t2_s4", data_out, 32'hA4); check("t2_v4", out_valid, 1);
    step(0, 0, 1); check("t2_drain_v", out_valid, 0); check("t2_drain_d", data_out, 32'hA4);

    // 3: backpressure holds the captured lane-2 value
    step(2, 1, 0); check("t3_cap", data_out, 32'hA2);
    for (int i = 0; i < 3; i++) begin
      lanes[2] = 32'hB0 + 32'(i);
      step(3 + i, 1, 0);
      check("t3_hold_d", data_out, 32'hA2);
      check("t3_hold_v", out_valid, 1);
      check("t3_hold_r", in_ready, 0);
    end
    c0 = consumed;
    step(0, 0, 1); check("t3_rel_v", out_valid, 0); check("t3_rel_d", data_out, 32'hA2);
    step(0, 0, 1);
    check("t3_once", consumed - c0, 1);
    lanes[2] = 32'hA2;

    // 4: out-of-range selects, back to back
    step(5, 1, 1); check("t4_d5", data_out, 32'hA0); check("t4_e5", sel_err, 1);
    step(6, 1, 1); check("t4_d6", data_out, 32'hA0); check("t4_e6", sel_err, 1);
    step(7, 1, 1); check("t4_d7", data_out, 32'hA0); check("t4_e7", sel_err, 1);
    check("t4_cnt3",  err_cnt,   8'd3);
    check("t4_sat3",  err_cnt_s, 2'd3);
    step(7, 1, 1);
    check("t4_cnt4",  err_cnt,   8'd4);
    check("t4_sat_hold", err_cnt_s, 2'd3);

    // 5: drain + accept every cycle
    sel5 = '{0, 2, 3, 4, 1, 0, 3, 2};
    exp5 = '{32'hA0, 32'hA2, 32'hA3, 32'hA4, 32'h4, 32'hA0, 32'hA3, 32'hA2};
    for (int i = 0; i < 8; i++) begin
      step(sel5[i], 1, 1);
      check("t5_data",  data_out,  exp5[i]);
      check("t5_valid", out_valid, 1);
      check("t5_err",   sel_err,   0);
    end

    // 6: asynchronous reset while stalled
    step(0, 0, 0);
    check("t6_stall_v", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_v",   out_valid, 0);
    check("t6_async_d",   data_out,  32'h0);
    check("t6_async_cnt", err_cnt,   8'h0);
    check("t6_async_sat", err_cnt_s, 2'h0);
    check("t6_async_r",   in_ready,  1);
    @(negedge clk);
    reset = 1'b1;
    step(3, 1, 1); check("t6_resume_d", data_out, 32'hA3); check("t6_resume_v", out_valid, 1);
    step(0, 0, 1); check("t6_end_v", out_valid, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
